test_status_monitor: RTL and testbench
======================================

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, word address of the pass/fail mailbox.
REQ-002 SHALL have parameter CONSOLE_ADDR, default 32'h0000_1004, word address of the byte console.
REQ-003 SHALL have parameter MAX_CYCLES, default 200000, timeout limit in enabled cycles, range 1..2^CNT_W-1.
REQ-004 SHALL have parameter CNT_W, default 32, width of the cycle counter.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port enable, input, 1, snoop and count only while high.
REQ-008 SHALL have ports mem_we (1), mem_addr (32), mem_wdata (32), mem_wmask (4), all inputs: CPU data-memory write bus, byte lane i = wdata[8i+7:8i].
REQ-009 SHALL have outputs done, pass, fail, timeout, each 1 bit, sticky status.
REQ-010 SHALL have output tohost_val, 32 bits: shadow of the mailbox word.
REQ-011 SHALL have output cycles, CNT_W bits: enabled cycles elapsed in RUN.
REQ-012 SHALL have outputs console_valid (1) and console_char (8): one-cycle console byte strobe.

Function
REQ-013 SHALL implement states RUN, PASS, FAIL, TIMEOUT; reset enters RUN.
REQ-014 Mailbox hit SHALL be: RUN, enable=1, mem_we=1, mem_wmask!=0, mem_addr[31:2]==TOHOST_ADDR[31:2]; addr[1:0] is ignored.
REQ-015 On a hit, tohost_val SHALL update at the next edge to a byte-lane merge: lanes with wmask=1 take wdata, other lanes keep the old value.
REQ-016 If the merged value is 0, the state SHALL stay RUN.
REQ-017 If the merged value is 32'd1, the state SHALL become PASS at the same edge.
REQ-018 If the merged value is any other nonzero value, the state SHALL become FAIL at the same edge.
REQ-019 done SHALL equal (state!=RUN).
REQ-020 pass, fail and timeout SHALL be one-hot decodes of PASS, FAIL and TIMEOUT.
REQ-021 All status outputs SHALL be registered, with latency exactly one edge after the terminating write cycle.
REQ-022 cycles SHALL increment by 1 on each edge where state==RUN and enable=1.
REQ-023 cycles SHALL hold when enable=0.
REQ-024 cycles SHALL freeze once done.
REQ-025 The state SHALL become TIMEOUT at the edge where state==RUN, enable=1, cycles==MAX_CYCLES-1 and there is no terminating mailbox hit; cycles then reads MAX_CYCLES.
REQ-026 On a simultaneous terminating mailbox hit and timeout, the mailbox SHALL win (PASS/FAIL).
REQ-027 Once done, the block SHALL ignore all writes; tohost_val, state and cycles SHALL hold until reset.
REQ-028 A console hit SHALL be: enable=1, mem_we=1, mem_wmask[0]=1, mem_addr[31:2]==CONSOLE_ADDR[31:2]; it is accepted in any state.
REQ-029 On a console hit, console_valid SHALL be 1 for exactly the next cycle with console_char=wdata[7:0]; back-to-back hits give back-to-back strobes.
REQ-030 When console_valid=0, console_char SHALL hold its last value.
REQ-031 Writes with mem_we=0, mem_wmask=0, or to other addresses SHALL have no effect.
REQ-032 If TOHOST_ADDR[31:2]==CONSOLE_ADDR[31:2], mailbox decode SHALL take priority and no console strobe SHALL occur.

Reset
REQ-033 When reset=1 at an edge, the block SHALL set state=RUN; done, pass, fail, timeout, console_valid = 0; tohost_val=0; cycles=0; console_char=8'h00.
REQ-034 Reset SHALL override all other inputs in the same cycle, including a mailbox hit.
REQ-035 Reset asserted mid-run or after done SHALL restart monitoring from cycles=0.

Verification
REQ-036 Pass: after 10 enabled cycles, write 32'h1 to 0x1000 with wmask 4'hF -> next cycle done=1, pass=1, tohost_val=1, cycles=11; later writes of 32'h5 leave all values unchanged.
REQ-037 Fail with byte merge: write 32'hAABBCC00 to 0x1000 with wmask 4'h1 -> no done; then write 32'h00000007 with wmask 4'h1 -> fail=1, tohost_val=32'h00000007.
REQ-038 Timeout: MAX_CYCLES=50, no writes, enable held high -> timeout=1 exactly 50 edges after reset release, cycles=50; pulling enable low for 5 cycles first delays this by 5.
REQ-039 Simultaneous events: 32'h1 written to mailbox on the cycle cycles==MAX_CYCLES-1 -> pass=1, timeout=0.
REQ-040 Console: "H","i" written on consecutive cycles to 0x1004 with wmask 4'h1 -> two adjacent strobes carrying 8'h48 then 8'h69; a write with wmask 4'h2 gives no strobe.
REQ-041 Reset mid-run: assert reset in the same cycle as a 32'h1 mailbox write -> pass=0, cycles=0, tohost_val=0 after the edge.

Source files
------------

// File: rtl/test_status_monitor.sv
// test_status_monitor
//   Snoops a CPU data-memory write bus to report the outcome of a test program.
//   A write to the TOHOST mailbox word ends the run: 1 means pass, any other
//   nonzero value means fail, 0 keeps the test running. A cycle counter gives a
//   timeout after MAX_CYCLES enabled cycles. Byte writes to the CONSOLE word are
//   forwarded as a one-cycle character strobe.
//
// Ports
//   clk, reset           : single clock, synchronous active-high reset
//   enable               : snoop and count only while high
//   mem_we/addr/wdata/wmask : write bus, byte lane i = wdata[8i+7:8i]
//   done/pass/fail/timeout  : sticky registered status
//   tohost_val           : shadow of the mailbox word
//   cycles               : enabled cycles elapsed while running
//   console_valid/char   : one-cycle console byte strobe
module test_status_monitor #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
    parameter int unsigned MAX_CYCLES   = 200000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      tohost_val,
    output logic [CNT_W-1:0] cycles,
    output logic             console_valid,
    output logic [7:0]       console_char
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    // Mailbox decode owns the word when both addresses share it.
    localparam logic             SAME_WORD = (TOHOST_ADDR[31:2] == CONSOLE_ADDR[31:2]);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_CYCLES - 1);

    state_t             state_q, state_d;
    logic [31:0]        tohost_q, tohost_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic               console_valid_q, console_valid_d;
    logic [7:0]         console_char_q, console_char_d;

    logic               mbox_hit;
    logic               con_hit;
    logic [31:0]        merged;

    // Word-aligned decode: the byte offset bits are deliberately ignored.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[1:0];

    always_comb begin
        mbox_hit = (state_q == ST_RUN) && enable && mem_we && (mem_wmask != '0)
                   && (mem_addr[31:2] == TOHOST_ADDR[31:2]);
        con_hit  = !SAME_WORD && enable && mem_we && mem_wmask[0]
                   && (mem_addr[31:2] == CONSOLE_ADDR[31:2]);

        merged = tohost_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mem_wmask[i]) begin
                merged[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        tohost_d        = tohost_q;
        cycles_d        = cycles_q;
        console_valid_d = con_hit;
        console_char_d  = con_hit ? mem_wdata[7:0] : console_char_q;

        if (state_q == ST_RUN && enable) begin
            cycles_d = cycles_q + CNT_W'(1);
            if (mbox_hit) begin
                tohost_d = merged;
            end
            // A terminating mailbox write beats a coincident timeout.
            if (mbox_hit && merged == 32'd1) begin
                state_d = ST_PASS;
            end else if (mbox_hit && merged != 32'd0) begin
                state_d = ST_FAIL;
            end else if (cycles_q == LAST_CNT) begin
                state_d = ST_TIMEOUT;
            end
        end

        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            tohost_q        <= '0;
            cycles_q        <= '0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            timeout_q       <= 1'b0;
            console_valid_q <= 1'b0;
            console_char_q  <= 8'h00;
        end else begin
            state_q         <= state_d;
            tohost_q        <= tohost_d;
            cycles_q        <= cycles_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
            timeout_q       <= timeout_d;
            console_valid_q <= console_valid_d;
            console_char_q  <= console_char_d;
        end
    end

    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign timeout       = timeout_q;
    assign tohost_val    = tohost_q;
    assign cycles        = cycles_q;
    assign console_valid = console_valid_q;
    assign console_char  = console_char_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: directed scenarios followed by randomized
// bus traffic, every edge compared against a behavioural outcome model.
module tb_test_status_monitor;

    localparam int unsigned MAXC = 50;
    localparam logic [31:0] TH   = 32'h0000_1000;
    localparam logic [31:0] CON  = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        done, pass, fail, timeout;
    logic [31:0] tohost_val;
    logic [31:0] cycles;
    logic        console_valid;
    logic [7:0]  console_char;

    test_status_monitor #(
        .TOHOST_ADDR (TH),
        .CONSOLE_ADDR(CON),
        .MAX_CYCLES  (MAXC),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .tohost_val   (tohost_val),
        .cycles       (cycles),
        .console_valid(console_valid),
        .console_char (console_char)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference outcome: 0 running, 1 passed, 2 failed, 3 timed out.
    int          m_outcome;
    logic [31:0] m_tohost;
    int unsigned m_cycles;
    logic        m_cv;
    logic [7:0]  m_cc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".done"},    32'(done),          32'(m_outcome != 0));
        chk({ctx, ".pass"},    32'(pass),          32'(m_outcome == 1));
        chk({ctx, ".fail"},    32'(fail),          32'(m_outcome == 2));
        chk({ctx, ".timeout"}, 32'(timeout),       32'(m_outcome == 3));
        chk({ctx, ".tohost"},  tohost_val,         m_tohost);
        chk({ctx, ".cycles"},  cycles,             m_cycles);
        chk({ctx, ".cvalid"},  32'(console_valid), 32'(m_cv));
        chk({ctx, ".cchar"},   32'(console_char),  32'(m_cc));
    endtask

    // Outcome rules evaluated on the inputs present before an edge.
    task automatic model(input logic r, e, w, input logic [31:0] a, d, input logic [3:0] m);
        logic [31:0] lanes, nv;
        if (r) begin
            m_outcome = 0; m_tohost = 0; m_cycles = 0; m_cv = 0; m_cc = 0;
            return;
        end
        m_cv = e && w && m[0] && (a / 4 == CON / 4);
        if (m_cv) m_cc = d[7:0];
        if (m_outcome == 0 && e) begin
            lanes = 0;
            for (int i = 0; i < 4; i++) if (m[i]) lanes = lanes | (32'hFF << (8 * i));
            nv = (m_tohost & ~lanes) | (d & lanes);
            if (w && m != 0 && a / 4 == TH / 4) begin
                m_tohost = nv;
                if (nv == 1) m_outcome = 1;
                else if (nv != 0) m_outcome = 2;
            end
            if (m_outcome == 0 && m_cycles + 1 == MAXC) m_outcome = 3;
            m_cycles = m_cycles + 1;
        end
    endtask

    task automatic step(input string ctx, input logic r, e, w,
                        input logic [31:0] a, d, input logic [3:0] m);
        reset = r; enable = e; mem_we = w; mem_addr = a; mem_wdata = d; mem_wmask = m;
        model(r, e, w, a, d, m);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n, input logic e);
        for (int i = 0; i < n; i++) step(ctx, 1'b0, e, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        step("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step("reset", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int          edges;
        logic [31:0] a, d;
        logic        r, e, w;

        m_outcome = 0; m_tohost = 0; m_cycles = 0; m_cv = 0; m_cc = 0;

        // Reset state
        do_reset();
        chk("rst_done", 32'(done), 32'd0);

        // Pass after 10 enabled cycles, later writes ignored
        idle("pre_pass", 10, 1'b1);
        step("pass_wr", 1'b0, 1'b1, 1'b1, 32'h1000, 32'h1, 4'hF);
        chk("pass_flag", 32'(pass), 32'd1);
        chk("pass_cycles", cycles, 32'd11);
        for (int i = 0; i < 3; i++) step("post_pass", 1'b0, 1'b1, 1'b1, 32'h1000, 32'h5, 4'hF);
        chk("pass_hold_val", tohost_val, 32'd1);
        chk("pass_hold_cyc", cycles, 32'd11);

        // Fail through byte merge
        do_reset();
        step("merge0", 1'b0, 1'b1, 1'b1, 32'h1000, 32'hAABBCC00, 4'h1);
        chk("merge0_done", 32'(done), 32'd0);
        step("merge1", 1'b0, 1'b1, 1'b1, 32'h1000, 32'h00000007, 4'h1);
        chk("merge1_fail", 32'(fail), 32'd1);
        chk("merge1_val", tohost_val, 32'h7);

        // Console strobes
        do_reset();
        step("con_H", 1'b0, 1'b1, 1'b1, 32'h1004, 32'h48, 4'h1);
        chk("con_H_char", 32'(console_char), 32'h48);
        step("con_i", 1'b0, 1'b1, 1'b1, 32'h1004, 32'h69, 4'h1);
        chk("con_i_valid", 32'(console_valid), 32'd1);
        chk("con_i_char", 32'(console_char), 32'h69);
        step("con_m2", 1'b0, 1'b1, 1'b1, 32'h1004, 32'h7A, 4'h2);
        chk("con_m2_valid", 32'(console_valid), 32'd0);
        idle("con_idle", 2, 1'b1);

        // Timeout with enable held high
        do_reset();
        edges = 0;
        while (!timeout && edges < 200) begin
            idle("to_run", 1, 1'b1);
            edges++;
        end
        chk("to_edges", 32'(edges), 32'd50);
        chk("to_cycles", cycles, 32'd50);

        // Timeout delayed by 5 disabled cycles
        do_reset();
        idle("to_dis", 5, 1'b0);
        edges = 5;
        while (!timeout && edges < 200) begin
            idle("to_run2", 1, 1'b1);
            edges++;
        end
        chk("to2_edges", 32'(edges), 32'd55);

        // Mailbox pass coinciding with the timeout edge
        do_reset();
        idle("sim_pre", 49, 1'b1);
        step("sim_wr", 1'b0, 1'b1, 1'b1, 32'h1000, 32'h1, 4'hF);
        chk("sim_pass", 32'(pass), 32'd1);
        chk("sim_timeout", 32'(timeout), 32'd0);

        // Reset wins over a same-cycle mailbox write
        idle("mid", 4, 1'b1);
        step("rst_wr", 1'b1, 1'b1, 1'b1, 32'h1000, 32'h1, 4'hF);
        chk("rst_wr_pass", 32'(pass), 32'd0);
        chk("rst_wr_cyc", cycles, 32'd0);
        chk("rst_wr_val", tohost_val, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 1) != 0;
            case ($urandom_range(0, 5))
                0: a = 32'h1000 | 32'($urandom_range(0, 3));
                1: a = 32'h1004 | 32'($urandom_range(0, 3));
                2: a = 32'h1008;
                3: a = 32'h0FFC;
                4: a = 32'h1000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: d = 32'h0;
                6: d = 32'h1;
                7: d = 32'h100;
                default: d = $urandom;
            endcase
            step("rand", r, e, w, a, d, 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
